// File: rtl/uart_pkg.sv
`default_nettype none
// ====================================================================
// uart_pkg : parity-mode and FSM state encodings shared by UART RX/TX
// Revision 1.0 - initial release
// ====================================================================
package uart_pkg;

  typedef logic [1:0] par_mode_t;

  localparam par_mode_t PAR_NONE = 2'd0;
  localparam par_mode_t PAR_EVEN = 2'd1;
  localparam par_mode_t PAR_ODD  = 2'd2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // data_xor is the XOR-reduction of the received data bits
  function automatic logic parity_error(input par_mode_t mode, input logic data_xor,
                                        input logic sample);
    case (mode)
      PAR_EVEN: return data_xor ^ sample;
      PAR_ODD:  return ~(data_xor ^ sample);
      default:  return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ====================================================================
// sync_2ff : two-flop synchronizer for a single asynchronous bit
// Revision 1.0 - initial release
// ====================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ====================================================================
// uart_rx_cfg : configurable UART receiver (data/parity/stop framing)
// Revision 1.0 - initial release
// ====================================================================
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 4,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [15:0] C_LAST_CNT  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] C_HALF_CNT  = 16'((CLK_PER_BIT - 1) / 2);
  localparam logic [2:0]  C_LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  C_LAST_STOP = 3'(STOP_BITS - 1);
  localparam par_mode_t   C_PAR_MODE  = par_mode_t'(PARITY);

  logic                 rx_s;
  logic                 bit_end;
  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 facc_q, facc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  assign bit_end = (cnt_q == C_LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    facc_d  = facc_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        facc_d = 1'b0;
        if (!rx_s && enable) state_d = ST_START;
      end
      ST_START: begin
        // Mid-start re-check rejects glitches shorter than half a bit
        if (cnt_q == C_HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == C_LAST_DATA) begin
            idx_d   = '0;
            state_d = (C_PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!rx_s) facc_d = 1'b1;
          if (idx_q == C_LAST_STOP) begin
            idx_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
            data_d  = shift_q;
            perr_d  = parity_error(C_PAR_MODE, ^shift_q, par_q);
            ferr_d  = facc_q | ~rx_s;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      facc_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      facc_q  <= facc_d;
      data_q  <= data_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign done       = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ====================================================================
// tb_uart_rx_cfg : five receiver configurations driven bit-serially
// Revision 1.0 - initial release
// ====================================================================
module tb_uart_rx_cfg;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       rx       [5];
  logic       en       [5];
  logic       done_w   [5];
  logic       perr_w   [5];
  logic       ferr_w   [5];
  logic       busy_w   [5];
  logic [7:0] dout0, dout1, dout2;
  logic [4:0] dout3;
  logic [6:0] dout4;

  int         n_tests;
  int         n_fail;
  int         done_cnt [5];
  logic [7:0] hist0 [$];

  // d0 8N1, d1 8E1, d2 8N2, d3 5N1 (all 4 clk/bit), d4 7O2 at 5 clk/bit
  uart_rx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .rst(rst), .rx(rx[0]), .enable(en[0]), .data_out(dout0), .done(done_w[0]),
    .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .busy(busy_w[0]));
  uart_rx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_d1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .enable(en[1]), .data_out(dout1), .done(done_w[1]),
    .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .busy(busy_w[1]));
  uart_rx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_d2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .enable(en[2]), .data_out(dout2), .done(done_w[2]),
    .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .busy(busy_w[2]));
  uart_rx_cfg #(.CLK_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_d3 (
    .clk(clk), .rst(rst), .rx(rx[3]), .enable(en[3]), .data_out(dout3), .done(done_w[3]),
    .parity_err(perr_w[3]), .frame_err(ferr_w[3]), .busy(busy_w[3]));
  uart_rx_cfg #(.CLK_PER_BIT(5), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_d4 (
    .clk(clk), .rst(rst), .rx(rx[4]), .enable(en[4]), .data_out(dout4), .done(done_w[4]),
    .parity_err(perr_w[4]), .frame_err(ferr_w[4]), .busy(busy_w[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) if (done_w[i] === 1'b1) done_cnt[i]++;
    if (done_w[0] === 1'b1) hist0.push_back(dout0);
  end

  function automatic int cfg_cpb(input int d);
    return (d == 4) ? 5 : 4;
  endfunction
  function automatic int cfg_nb(input int d);
    case (d)
      3:       return 5;
      4:       return 7;
      default: return 8;
    endcase
  endfunction
  function automatic int cfg_par(input int d);
    case (d)
      1:       return 1;
      4:       return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int cfg_ns(input int d);
    return (d == 2 || d == 4) ? 2 : 1;
  endfunction

  function automatic logic [7:0] get_dout(input int d);
    case (d)
      0:       return dout0;
      1:       return dout1;
      2:       return dout2;
      3:       return {3'b000, dout3};
      default: return {1'b0, dout4};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int d, input logic v, input int cpb);
    rx[d] = v;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stop, input int gap);
    int cpb;
    cpb = cfg_cpb(d);
    drive_bit(d, 1'b0, cpb);
    for (int i = 0; i < cfg_nb(d); i++) drive_bit(d, data[i], cpb);
    if (cfg_par(d) != 0) drive_bit(d, pbit, cpb);
    for (int i = 0; i < cfg_ns(d); i++) drive_bit(d, stop[i], cpb);
    for (int i = 0; i < gap; i++) drive_bit(d, 1'b1, cpb);
  endtask

  task automatic check_outputs_zero(input int d, input string tag);
    check($sformatf("%s d%0d data_out", tag, d), get_dout(d), 0);
    check($sformatf("%s d%0d done", tag, d), done_w[d], 0);
    check($sformatf("%s d%0d parity_err", tag, d), perr_w[d], 0);
    check($sformatf("%s d%0d frame_err", tag, d), ferr_w[d], 0);
    check($sformatf("%s d%0d busy", tag, d), busy_w[d], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [8];
    int         c, d, h, ones, nb;
    logic [7:0] data;
    logic       pbit, eperr, eferr;
    logic [1:0] stop;

    tbl[0] = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1, 8'h03, 1'b1, 2'b11, 8'h03, 1'b1, 1'b0};
    tbl[2] = '{1, 8'h03, 1'b0, 2'b11, 8'h03, 1'b0, 1'b0};
    tbl[3] = '{2, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
    tbl[4] = '{2, 8'h5A, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0};
    tbl[5] = '{0, 8'h3C, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b1};
    tbl[6] = '{3, 8'h1F, 1'b0, 2'b11, 8'h1F, 1'b0, 1'b0};
    tbl[7] = '{4, 8'h55, 1'b1, 2'b11, 8'h55, 1'b0, 1'b0};

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx[i]       = 1'b1;
      en[i]       = 1'b1;
      done_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) check_outputs_zero(i, "reset");

    // Directed framing vectors
    for (int i = 0; i < 8; i++) begin
      d = tbl[i].dut;
      c = done_cnt[d];
      send_frame(d, tbl[i].data, tbl[i].pbit, tbl[i].stop, 2);
      check($sformatf("vec%0d done pulses", i), done_cnt[d] - c, 1);
      check($sformatf("vec%0d data_out", i), get_dout(d), tbl[i].exp_data);
      check($sformatf("vec%0d parity_err", i), perr_w[d], tbl[i].exp_perr);
      check($sformatf("vec%0d frame_err", i), ferr_w[d], tbl[i].exp_ferr);
    end

    // One-cycle glitch while idle: enters START, then rejected
    c = done_cnt[0];
    data = dout0;
    rx[0] = 1'b0;
    @(negedge clk);
    rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch busy in start", busy_w[0], 1);
    repeat (12) @(negedge clk);
    check("glitch busy after", busy_w[0], 0);
    check("glitch no done", done_cnt[0] - c, 0);
    check("glitch data_out kept", dout0, data);

    // Back-to-back frames with no idle gap
    c = done_cnt[0];
    h = hist0.size();
    send_frame(0, 8'h11, 1'b0, 2'b11, 0);
    send_frame(0, 8'hEE, 1'b0, 2'b11, 3);
    check("b2b done pulses", done_cnt[0] - c, 2);
    check("b2b first word", (hist0.size() > h) ? hist0[h] : 8'hXX, 8'h11);
    check("b2b second word", (hist0.size() > h + 1) ? hist0[h+1] : 8'hXX, 8'hEE);

    // Reset in the middle of the second of two back-to-back frames
    send_frame(0, 8'h11, 1'b0, 2'b11, 0);
    drive_bit(0, 1'b0, 4);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'(8'hEE >> i), 4);
    c = done_cnt[0];
    check("pre-reset data_out", dout0, 8'h11);
    check("pre-reset busy", busy_w[0], 1);
    rst   = 1'b1;
    rx[0] = 1'b1;
    @(negedge clk);
    check_outputs_zero(0, "midframe reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midframe reset no done", done_cnt[0] - c, 0);
    check("midframe reset data_out", dout0, 0);

    // enable dropped mid-frame does not abort; start ignored while low
    c = done_cnt[3];
    fork
      send_frame(3, 8'h1F, 1'b0, 2'b11, 2);
      begin
        repeat (10) @(negedge clk);
        en[3] = 1'b0;
      end
    join
    check("en-drop done pulses", done_cnt[3] - c, 1);
    check("en-drop data_out", dout3, 5'h1F);
    c = done_cnt[3];
    fork
      send_frame(3, 8'h0A, 1'b0, 2'b11, 2);
      begin
        repeat (6) @(negedge clk);
        check("disabled busy", busy_w[3], 0);
      end
    join
    check("disabled no done", done_cnt[3] - c, 0);
    check("disabled data_out", dout3, 5'h1F);
    en[3] = 1'b1;

    // Random frames on the parity-carrying configurations
    for (int k = 0; k < 2; k++) begin
      d  = (k == 0) ? 1 : 4;
      nb = cfg_nb(d);
      for (int n = 0; n < 25; n++) begin
        data = 8'($urandom_range(0, 255)) & 8'((1 << nb) - 1);
        pbit = 1'($urandom_range(0, 1));
        stop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        ones = $countones(data) + int'(pbit);
        eperr = (cfg_par(d) == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
        eferr = 1'b0;
        for (int j = 0; j < cfg_ns(d); j++) if (!stop[j]) eferr = 1'b1;
        c = done_cnt[d];
        send_frame(d, data, pbit, stop, int'($urandom_range(1, 3)));
        check($sformatf("rnd d%0d #%0d done pulses", d, n), done_cnt[d] - c, 1);
        check($sformatf("rnd d%0d #%0d data_out", d, n), get_dout(d), data);
        check($sformatf("rnd d%0d #%0d parity_err", d, n), perr_w[d], eperr);
        check($sformatf("rnd d%0d #%0d frame_err", d, n), ferr_w[d], eferr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL provide parameter CLK_PER_BIT, default 4; clock cycles per bit (clk frequency / baud), legal range 4..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8; data bits per frame, legal 5..8, LSB first.
REQ-003 SHALL provide parameter PARITY, default 0; 0 none, 1 even, 2 odd.
REQ-004 SHALL provide parameter STOP_BITS, default 1; legal 1 or 2.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port enable  input  1  permits start-bit detection.
REQ-009 SHALL have port data_out  output  DATA_BITS  last received word.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a frame completes.
REQ-011 SHALL have port parity_err  output  1  parity mismatch of the frame flagged by done.
REQ-012 SHALL have port frame_err  output  1  stop bit sampled low in the frame flagged by done.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle latency).
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: clk_count=0, bit index=0; go to START when rx_s==0 and enable==1; else stay.
REQ-017 START: count to (CLK_PER_BIT-1)/2; at that count, rx_s==0 -> clear count, go to DATA; rx_s==1 -> IDLE (glitch rejected, no done).
REQ-018 DATA: sample rx_s into bit[index] when clk_count==CLK_PER_BIT-1, then clear count; after bit DATA_BITS-1, go to PARITY if PARITY!=0, else STOP.
REQ-019 PARITY: sample after CLK_PER_BIT cycles; error when XOR(data, sample) is 1 (even) or 0 (odd).
REQ-020 STOP: sample each stop bit after CLK_PER_BIT cycles; any low stop sample sets the frame error.
REQ-021 Sampling the last stop bit SHALL go to IDLE and, in the same edge, load data_out, parity_err, frame_err and set done=1.
REQ-022 A frame SHALL therefore occupy one half-bit and (DATA_BITS + parity + STOP_BITS) bit periods after the edge is detected; back-to-back frames SHALL be received without loss.
REQ-023 done SHALL be high for exactly one cycle per frame; parity_err and frame_err SHALL hold until the next done.
REQ-024 data_out SHALL be updated even when an error flag is set; it SHALL be unchanged by frames aborted in START.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the frame; enable only gates IDLE->START.
REQ-026 Unused parity bit: with PARITY=0, parity_err SHALL stay 0.
REQ-027 Illegal state encodings SHALL return to IDLE with count and index cleared.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, clear count, index, shift data and synchronizer flops to 1 (idle line).
REQ-029 Reset values: data_out=0, done=0, parity_err=0, frame_err=0, busy=0.
REQ-030 Reset mid-frame SHALL discard the partial frame with no done pulse.

Structure
REQ-031 Parity-mode and state encodings SHALL live in shared package uart_pkg, for reuse by the matching transmitter.
REQ-032 The two-flop synchronizer SHALL be sub-module sync_2ff; the bit timer and FSM remain in uart_rx_cfg.

Verification
REQ-033 Defaults, frame 0xA5, 8N1 -> data_out=0xA5, done for 1 cycle, both errors 0.
REQ-034 PARITY=1, frame 0x03 with parity bit 1 -> done, data_out=0x03, parity_err=1; correct parity bit 0 -> parity_err=0.
REQ-035 STOP_BITS=2, second stop bit driven low, byte 0x5A -> data_out=0x5A, frame_err=1.
REQ-036 rx low pulse of 1 cycle while idle -> returns to IDLE, no done, data_out unchanged.
REQ-037 Two back-to-back frames 0x11, 0xEE with no idle gap -> two done pulses, values in order; rst asserted mid-second frame -> all outputs 0, no second done.
REQ-038 DATA_BITS=5, frame 0x1F then enable=0 mid-frame -> frame completes with data_out=0x1F; subsequent start edge ignored while enable=0.
